// File: rtl/load_store_unit.sv
// MIPS load/store unit: one bus transaction per start, handling LB/LH/LW/LBU/LHU/LWL/LWR and SB/SH/SW
// with byte-lane steering, load extension/merge and alignment checking. All outputs are registered.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        done,
    output logic        wb_en,
    output logic [31:0] wb_data,
    output logic        addr_error,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LWL = 6'b100010;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWR = 6'b100110;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    function automatic logic supported(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic aligned(input logic [5:0] op, input logic [1:0] b);
        case (op)
            OP_LH, OP_LHU, OP_SH: return ~b[0];
            OP_LW, OP_SW:         return b == 2'b00;
            default:              return 1'b1;
        endcase
    endfunction

    // All supported stores are 101xxx, all supported loads 100xxx.
    function automatic logic is_store(input logic [5:0] op);
        return op[3];
    endfunction

    function automatic logic [3:0] byte_enable(input logic [5:0] op, input logic [1:0] b);
        logic [1:0] nb;
        nb = 2'd3 - b;
        case (op)
            OP_LB, OP_LBU, OP_SB: return 4'b0001 << b;
            OP_LH, OP_LHU, OP_SH: return b[1] ? 4'b1100 : 4'b0011;
            OP_LWL:               return 4'b1111 >> nb;
            OP_LWR:               return 4'b1111 << b;
            default:              return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [5:0] op, input logic [31:0] rt);
        case (op)
            OP_SB:   return {4{rt[7:0]}};
            OP_SH:   return {2{rt[15:0]}};
            default: return rt;
        endcase
    endfunction

    function automatic logic [31:0] load_result(input logic [5:0] op, input logic [1:0] b,
                                                input logic [31:0] rd, input logic [31:0] rt);
        logic [1:0]  nb;
        logic [31:0] sh;
        logic [15:0] hw;
        nb = 2'd3 - b;
        sh = rd >> {b, 3'b000};
        hw = b[1] ? rd[31:16] : rd[15:0];
        case (op)
            OP_LB:   return {{24{sh[7]}}, sh[7:0]};
            OP_LBU:  return {24'h0, sh[7:0]};
            OP_LH:   return {{16{hw[15]}}, hw};
            OP_LHU:  return {16'h0, hw};
            // Unaligned word halves: memory bytes fill one end, rt keeps the rest.
            OP_LWL:  return (rd << {nb, 3'b000}) | (rt & (32'h00FF_FFFF >> {b, 3'b000}));
            OP_LWR:  return (rd >> {b, 3'b000}) | (rt & ~(32'hFFFF_FFFF >> {b, 3'b000}));
            default: return rd;
        endcase
    endfunction

    logic [1:0]  state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [1:0]  b_q, b_d;
    logic [31:0] rt_q, rt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        wb_en_q, wb_en_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        addr_error_q, addr_error_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [3:0]  mem_byteenable_q, mem_byteenable_d;
    logic [31:0] mem_writedata_q, mem_writedata_d;

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        b_d              = b_q;
        rt_d             = rt_q;
        busy_d           = busy_q;
        done_d           = done_q;
        wb_en_d          = wb_en_q;
        wb_data_d        = wb_data_q;
        addr_error_d     = addr_error_q;
        mem_address_d    = mem_address_q;
        mem_read_d       = mem_read_q;
        mem_write_d      = mem_write_q;
        mem_byteenable_d = mem_byteenable_q;
        mem_writedata_d  = mem_writedata_q;

        case (state_q)
            IDLE: begin
                busy_d       = 1'b0;
                done_d       = 1'b0;
                wb_en_d      = 1'b0;
                addr_error_d = 1'b0;
                mem_read_d   = 1'b0;
                mem_write_d  = 1'b0;
                if (start) begin
                    op_d   = opcode;
                    b_d    = addr[1:0];
                    rt_d   = rt_data;
                    busy_d = 1'b1;
                    if (!supported(opcode)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (!aligned(opcode, addr[1:0])) begin
                        state_d      = DONE;
                        done_d       = 1'b1;
                        addr_error_d = 1'b1;
                    end else begin
                        state_d          = REQ;
                        mem_address_d    = {addr[31:2], 2'b00};
                        mem_read_d       = ~is_store(opcode);
                        mem_write_d      = is_store(opcode);
                        mem_byteenable_d = byte_enable(opcode, addr[1:0]);
                        mem_writedata_d  = is_store(opcode) ? store_data(opcode, rt_data)
                                                            : 32'h0;
                    end
                end
            end
            REQ: begin
                if (!mem_waitrequest) begin
                    state_d     = DONE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    done_d      = 1'b1;
                    if (!is_store(op_q)) begin
                        wb_en_d   = 1'b1;
                        wb_data_d = load_result(op_q, b_q, mem_readdata, rt_q);
                    end
                end
            end
            DONE: begin
                state_d      = IDLE;
                busy_d       = 1'b0;
                done_d       = 1'b0;
                wb_en_d      = 1'b0;
                addr_error_d = 1'b0;
            end
            default: begin
                state_d      = IDLE;
                busy_d       = 1'b0;
                done_d       = 1'b0;
                wb_en_d      = 1'b0;
                addr_error_d = 1'b0;
                mem_read_d   = 1'b0;
                mem_write_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= IDLE;
            op_q             <= 6'h0;
            b_q              <= 2'h0;
            rt_q             <= 32'h0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            wb_en_q          <= 1'b0;
            wb_data_q        <= 32'h0;
            addr_error_q     <= 1'b0;
            mem_address_q    <= 32'h0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_byteenable_q <= 4'h0;
            mem_writedata_q  <= 32'h0;
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            b_q              <= b_d;
            rt_q             <= rt_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            wb_en_q          <= wb_en_d;
            wb_data_q        <= wb_data_d;
            addr_error_q     <= addr_error_d;
            mem_address_q    <= mem_address_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_byteenable_q <= mem_byteenable_d;
            mem_writedata_q  <= mem_writedata_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign wb_en          = wb_en_q;
    assign wb_data        = wb_data_q;
    assign addr_error     = addr_error_q;
    assign mem_address    = mem_address_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_byteenable = mem_byteenable_q;
    assign mem_writedata  = mem_writedata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level reference model, per-cycle output comparison,
// directed literal cases, reset abort during a stall, and randomized back-to-back traffic.
module tb_load_store_unit;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LWL = 6'b100010;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWR = 6'b100110;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    logic [5:0] ops [10] = '{OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
                             OP_SB, OP_SH, OP_SW};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  opcode = 6'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] rt_data = 32'h0;
    logic        busy, done, wb_en, addr_error, mem_read, mem_write;
    logic [31:0] wb_data, mem_address, mem_writedata;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata = 32'h0;
    logic        mem_waitrequest = 1'b0;

    load_store_unit dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .opcode          (opcode),
        .addr            (addr),
        .rt_data         (rt_data),
        .busy            (busy),
        .done            (done),
        .wb_en           (wb_en),
        .wb_data         (wb_data),
        .addr_error      (addr_error),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byteenable  (mem_byteenable),
        .mem_writedata   (mem_writedata),
        .mem_readdata    (mem_readdata),
        .mem_waitrequest (mem_waitrequest)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_supported(input logic [5:0] op);
        for (int i = 0; i < 10; i++) if (ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_store(input logic [5:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic bit m_misaligned(input logic [5:0] op, input logic [31:0] a);
        int size;
        size = 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) size = 2;
        if (op == OP_LW || op == OP_SW) size = 4;
        return (a % size) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [5:0] op, input logic [1:0] b);
        logic [3:0] be;
        int bi;
        bi = int'(b);
        for (int i = 0; i < 4; i++) begin
            case (op)
                OP_LB, OP_LBU, OP_SB: be[i] = (i == bi);
                OP_LH, OP_LHU, OP_SH: be[i] = (i / 2 == bi / 2);
                OP_LWL:               be[i] = (i <= bi);
                OP_LWR:               be[i] = (i >= bi);
                default:              be[i] = 1'b1;
            endcase
        end
        return be;
    endfunction

    function automatic logic [31:0] m_wd(input logic [5:0] op, input logic [31:0] rt);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            if (op == OP_SB) w[8*i +: 8] = rt[7:0];
            else if (op == OP_SH) w[8*i +: 8] = rt[8*(i%2) +: 8];
            else w[8*i +: 8] = rt[8*i +: 8];
        end
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [5:0] op, input logic [1:0] b,
                                           input logic [31:0] rd, input logic [31:0] rt);
        logic [7:0]  rb [4];
        logic [7:0]  tb [4];
        logic [31:0] o;
        logic [15:0] h;
        int bi;
        bi = int'(b);
        for (int i = 0; i < 4; i++) begin
            rb[i] = rd[8*i +: 8];
            tb[i] = rt[8*i +: 8];
        end
        h = {rb[2*(bi/2)+1], rb[2*(bi/2)]};
        case (op)
            OP_LB:  o = {{24{rb[bi][7]}}, rb[bi]};
            OP_LBU: o = {24'h0, rb[bi]};
            OP_LH:  o = {{16{h[15]}}, h};
            OP_LHU: o = {16'h0, h};
            OP_LWL: for (int i = 0; i < 4; i++) begin
                if (i >= 3 - bi) o[8*i +: 8] = rb[i - (3 - bi)];
                else o[8*i +: 8] = tb[i];
            end
            OP_LWR: for (int i = 0; i < 4; i++) begin
                if (i <= 3 - bi) o[8*i +: 8] = rb[i + bi];
                else o[8*i +: 8] = tb[i];
            end
            default: o = rd;
        endcase
        return o;
    endfunction

    // ---------------- per-cycle compare ----------------
    bit          chk_en = 1'b0;
    bit          e_busy, e_done, e_wb_en, e_err, e_rd, e_wr, e_zero;
    logic [31:0] e_wb, e_ma, e_wd;
    logic [3:0]  e_be;
    logic [31:0] seen_wb, seen_wd;
    logic [3:0]  seen_be;
    logic        seen_err;

    always @(negedge clk) begin
        if (chk_en) begin
            chk1("busy", busy, e_busy);
            chk1("done", done, e_done);
            chk1("wb_en", wb_en, e_wb_en);
            chk1("mem_read", mem_read, e_rd);
            chk1("mem_write", mem_write, e_wr);
            if (e_done) begin
                chk1("addr_error", addr_error, e_err);
                seen_err = addr_error;
            end
            if (e_wb_en) begin
                chk32("wb_data", wb_data, e_wb);
                seen_wb = wb_data;
            end
            if (e_rd || e_wr) begin
                chk32("mem_address", mem_address, e_ma);
                chk4("mem_byteenable", mem_byteenable, e_be);
                seen_be = mem_byteenable;
            end
            if (e_wr) begin
                chk32("mem_writedata", mem_writedata, e_wd);
                seen_wd = mem_writedata;
            end
            if (e_zero) begin
                chk32("reset_wb_data", wb_data, 32'h0);
                chk1("reset_addr_error", addr_error, 1'b0);
                chk32("reset_mem_address", mem_address, 32'h0);
                chk4("reset_mem_byteenable", mem_byteenable, 4'h0);
                chk32("reset_mem_writedata", mem_writedata, 32'h0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        e_busy = 0; e_done = 0; e_wb_en = 0; e_err = 0; e_rd = 0; e_wr = 0; e_zero = 0;
    endtask

    // A request that must be ignored while busy.
    task automatic junk_start();
        start  = 1'($urandom_range(0, 1));
        opcode = OP_LB;
        addr   = $urandom;
    endtask

    task automatic run_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt,
                           input logic [31:0] rd, input int waits);
        bit st;
        st = m_store(op);
        set_idle();
        start = 1'b1; opcode = op; addr = a; rt_data = rt;
        mem_waitrequest = 1'($urandom_range(0, 1));
        step();
        if (!m_supported(op) || m_misaligned(op, a)) begin
            junk_start();
            e_busy = 1; e_done = 1; e_err = m_supported(op);
            step();
        end else begin
            for (int k = 0; k <= waits; k++) begin
                junk_start();
                e_busy = 1; e_rd = !st; e_wr = st;
                e_ma = {a[31:2], 2'b00}; e_be = m_be(op, a[1:0]); e_wd = m_wd(op, rt);
                mem_waitrequest = (k < waits);
                mem_readdata = (k == waits) ? rd : $urandom;
                step();
            end
            junk_start();
            mem_waitrequest = 1'($urandom_range(0, 1));
            e_rd = 0; e_wr = 0; e_busy = 1; e_done = 1; e_err = 0;
            e_wb_en = !st; e_wb = m_load(op, a[1:0], rd, rt);
            step();
        end
        start = 1'b0;
        set_idle();
    endtask

    task automatic clear_seen();
        seen_wb = 32'h0; seen_wd = 32'h0; seen_be = 4'h0; seen_err = 1'b0;
    endtask

    initial begin
        set_idle();
        step();
        e_zero = 1'b1;
        chk_en = 1'b1;
        step();
        reset = 1'b1;
        set_idle();
        step();

        clear_seen();
        run_txn(OP_LB, 32'h1003, 32'h1234_5678, 32'h80FF_FF12, 0);
        chk4("lb_be", seen_be, 4'b1000);
        chk32("lb_wb", seen_wb, 32'hFFFF_FF80);

        clear_seen();
        run_txn(OP_LHU, 32'h2002, 32'h0, 32'h8765_4321, 3);
        chk4("lhu_be", seen_be, 4'b1100);
        chk32("lhu_wb", seen_wb, 32'h0000_8765);

        clear_seen();
        run_txn(OP_LWL, 32'h10, 32'hAABB_CCDD, 32'h1122_3344, 0);
        chk4("lwl_be", seen_be, 4'b0001);
        chk32("lwl_wb", seen_wb, 32'h44BB_CCDD);

        clear_seen();
        run_txn(OP_LWR, 32'h13, 32'hAABB_CCDD, 32'h1122_3344, 1);
        chk4("lwr_be", seen_be, 4'b1000);
        chk32("lwr_wb", seen_wb, 32'hAABB_CC11);

        clear_seen();
        run_txn(OP_LW, 32'h0002, 32'h0, 32'h0, 0);
        chk1("lw_misaligned_err", seen_err, 1'b1);

        clear_seen();
        run_txn(OP_SH, 32'h6, 32'h0000_BEEF, 32'h0, 0);
        chk4("sh_be", seen_be, 4'b1100);
        chk32("sh_wd", seen_wd, 32'hBEEF_BEEF);

        clear_seen();
        run_txn(6'b000000, 32'h0, 32'h0, 32'h0, 0);
        chk1("unsupported_err", seen_err, 1'b0);

        // Reset during a waitrequest stall aborts the read with no done pulse.
        set_idle();
        start = 1'b1; opcode = OP_LHU; addr = 32'h40;
        step();
        for (int k = 0; k < 2; k++) begin
            start = 1'b1; opcode = OP_SW; addr = 32'h80;
            mem_waitrequest = 1'b1;
            e_busy = 1; e_rd = 1; e_ma = 32'h40; e_be = 4'b0011;
            step();
        end
        reset = 1'b0; start = 1'b0;
        e_busy = 1; e_rd = 1;
        step();
        set_idle();
        e_zero = 1'b1;
        reset = 1'b1;
        step();
        set_idle();
        mem_waitrequest = 1'b0;
        step();
        step();

        repeat (300) begin
            logic [5:0] op;
            int sel;
            sel = int'($urandom_range(0, 11));
            if (sel < 10) op = ops[sel];
            else op = (sel == 10) ? 6'b000000 : 6'b101111;
            run_txn(op, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) step();
        end

        step();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters: none; the block SHALL have no parameters.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 reset  in  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-004 start  in  1  one-cycle request from control; honoured only in IDLE.
REQ-005 opcode  in  6  MIPS opcode: LB 100000, LH 100001, LWL 100010, LW 100011, LBU 100100, LHU 100101, LWR 100110, SB 101000, SH 101001, SW 101011.
REQ-006 addr  in  32  effective byte address.
REQ-007 rt_data  in  32  current rt value: store data, or merge source for LWL/LWR.
REQ-008 busy  out  1  high in any state other than IDLE.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 wb_en  out  1  register write strobe, coincident with done, loads only.
REQ-011 wb_data  out  32  final 32-bit value for register rt.
REQ-012 addr_error  out  1  misaligned access flag, valid with done.
REQ-013 mem_address  out  32  word-aligned bus address: {addr[31:2],2'b00}.
REQ-014 mem_read / mem_write  out  1 each  bus strobes, mutually exclusive.
REQ-015 mem_byteenable  out  4  active byte lanes; lane i = bits [8i+7:8i], little-endian.
REQ-016 mem_writedata  out  32  store data shifted into the active lanes.
REQ-017 mem_readdata  in  32  read data, valid on the cycle mem_read is high and mem_waitrequest is low.
REQ-018 mem_waitrequest  in  1  bus stall; strobes and address are held while it is high.

Function
REQ-019 FSM states SHALL be IDLE, REQ, DONE; all outputs SHALL be registered.
REQ-020 IDLE + start + aligned, supported opcode -> REQ; the request fields SHALL be latched on that edge.
REQ-021 Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0; LB/LBU/SB/LWL/LWR are always aligned.
REQ-022 IDLE + start + misaligned -> DONE with addr_error=1; no bus strobe and wb_en=0.
REQ-023 IDLE + start + unsupported opcode -> DONE with addr_error=0 and wb_en=0; no bus access.
REQ-024 In REQ, mem_read (loads) or mem_write (stores) SHALL be high with constant address, byteenable and writedata.
REQ-025 REQ + mem_waitrequest=0 -> DONE; loads capture mem_readdata on that edge.
REQ-026 REQ + mem_waitrequest=1 -> stay in REQ, with no limit on wait cycles.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE; wb_en=1 only for error-free loads.
REQ-028 Latency with zero wait states: start at cycle 0, strobe at cycle 1, done at cycle 2; each wait cycle adds 1.
REQ-029 start SHALL be ignored while busy=1; the first new request is accepted in the IDLE cycle after DONE.
REQ-030 Byteenable with b=addr[1:0]:
  - LB/LBU/SB: 1<<b.
  - LH/LHU/SH: 0011 when b=0, 1100 when b=2.
  - LW/SW: 1111.
  - LWL: lanes 0..b.
  - LWR: lanes b..3.
REQ-031 LB/LBU SHALL select byte b; LB sign-extends from bit 7 and LBU zero-extends.
REQ-032 LH/LHU SHALL select halfword b[1]; LH sign-extends from bit 15 and LHU zero-extends.
REQ-033 LW SHALL return mem_readdata unchanged.
REQ-034 LWL: wb_data = (rd << 8*(3-b)) OR (rt_data AND low (3-b) bytes mask).
REQ-035 LWR: wb_data = (rd >> 8*b) OR (rt_data AND high b bytes mask).
REQ-036 Stores: mem_writedata = rt_data low byte/halfword/word replicated across lanes (SB x4, SH x2); wb_en=0.

Reset
REQ-037 reset=0 at an edge SHALL force IDLE and zero every output, including deasserting mem_read/mem_write on that edge, even mid-REQ.
REQ-038 A transaction aborted by reset SHALL NOT pulse done or wb_en.

Verification
REQ-039 LB addr=0x1003, rd=0x80FF_FF12, 0 waits -> byteenable=1000, done at cycle 2, wb_data=0xFFFF_FF80.
REQ-040 LHU addr=0x2002, rd=0x8765_4321, 3 waits -> mem_read high for cycles 1-4, done at cycle 5, wb_data=0x0000_8765.
REQ-041 LWL addr=0x10 (b=0), rt=0xAABB_CCDD, rd=0x1122_3344 -> byteenable=0001, wb_data=0x44BB_CCDD; LWR with b=3 on the same data -> byteenable=1000, wb_data=0xAABB_CC11.
REQ-042 LW addr=0x0002 -> no strobe, done at cycle 1, addr_error=1, wb_en=0; SH addr=0x6, rt=0x0000_BEEF -> mem_write, byteenable=1100, writedata=0xBEEF_BEEF.
REQ-043 reset=0 during a waitrequest stall -> mem_read=0 on the next edge, no done pulse; a start while busy is ignored.
